fifo_bist_ctrl: RTL and testbench
=================================

Name: fifo_bist_ctrl

Overview:
Single-clock BIST sequencer for the 10-entry x 10-bit FIFO under test.
- Runs one complete test pass: fill phase, full-flag check, drain phase, empty-flag check.
- Drives W_EN to the walking-ones data generator and R_EN to the read-address counter.
- Regenerates the walking-ones pattern internally and compares it against FIFO read data.
- Reports PASS/FAIL, mismatch count, first failing index and flag errors to the test host.

Parameters:
DEPTH, 10, FIFO entries and number of writes/reads per pass
WIDTH, 10, data width; expected pattern is a WIDTH-bit ring, seed 1
RD_LAT, 1, cycles from R_EN assertion to valid RDATA (1..3)
CW, 4, counter/index width; must satisfy 2**CW > DEPTH

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-low reset
START  in  1  begin a pass; honoured only in IDLE or DONE
FULL  in  1  FIFO full flag
EMPTY  in  1  FIFO empty flag
RDATA  in  WIDTH  FIFO read data
W_EN  out  1  write/advance enable to data generator and FIFO
R_EN  out  1  read/advance enable to address counter and FIFO
BUSY  out  1  pass in progress
DONE  out  1  results valid; held until next START
PASS  out  1  ERR_CNT==0 and FLAG_ERR==0; qualified by DONE
ERR_CNT  out  CW  data mismatches, saturating at 2**CW-1
FAIL_IDX  out  CW  read index (0..DEPTH-1) of first mismatch
FLAG_ERR  out  1  sticky: FULL/EMPTY misbehaved during pass

Behaviour:
Reset (RST low, asynchronous, any state):
- All outputs 0; state IDLE; expected pattern = 1; all counters = 0.
- Mid-pass reset aborts the pass immediately. No partial result survives.

States: IDLE, WRITE, CHK_FULL, READ, DRAIN, CHK_EMPTY, DONE.

IDLE/DONE:
- START=1 enters WRITE next cycle.
- On that same edge: clear ERR_CNT, FAIL_IDX, FLAG_ERR, DONE; reload expected = 1; clear counters.
- BUSY=1 from the WRITE cycle onward.
- START is ignored in every other state.

WRITE:
- W_EN = !FULL, combinational from state.
- Write counter increments on each cycle with W_EN=1.
- FULL=1 while write count < DEPTH sets FLAG_ERR and jumps to CHK_FULL.
- When write count reaches DEPTH, go to CHK_FULL. Exactly DEPTH W_EN pulses on a healthy FIFO.

CHK_FULL:
- One cycle, W_EN=0. FULL must be 1; otherwise set FLAG_ERR. Then go to READ.
- Both a premature-full error and a missing-full error may set FLAG_ERR in the same pass; FLAG_ERR stays 1.

READ:
- R_EN = !EMPTY.
- Each issued read shifts a 1 into an RD_LAT-deep valid pipe, tagged with its read index 0..DEPTH-1.
- EMPTY=1 before DEPTH reads sets FLAG_ERR and jumps to DRAIN.
- After DEPTH reads, go to DRAIN.

Compare (any state):
- Fires when the valid pipe output is 1.
- RDATA != expected: ERR_CNT saturating-increments. FAIL_IDX latches the tag only on the first mismatch of the pass.
- Expected rotates left by 1 per compare, MSB into LSB. It wraps to 1 after WIDTH rotations, matching the generator ring.

DRAIN:
- R_EN=0. Wait RD_LAT cycles so all in-flight compares retire, then go to CHK_EMPTY.

CHK_EMPTY:
- One cycle. EMPTY must be 1; otherwise set FLAG_ERR. Then go to DONE.

DONE:
- DONE=1, BUSY=0. PASS registered on DONE entry. All results held until START.

Cycle count:
- A clean pass takes DEPTH+1+DEPTH+RD_LAT+1 cycles in BUSY.
- Defaults: 23 cycles.

W_EN and R_EN are never both 1.

Decomposition:
Shared package fifo_bist_pkg holds:
- state_t enum
- DEPTH/WIDTH defaults
- function rotl1 (ring advance, shared with the generator model)

Sub-module bist_cmp_pipe: RD_LAT-stage valid/index shift pipe plus comparator and saturating error counter. The FSM stays in fifo_bist_ctrl.

Test Plan:
- Ideal FIFO model, RD_LAT=1, START pulse → 10 W_EN pulses; FULL seen in CHK_FULL; 10 R_EN pulses; DONE at BUSY cycle 23; PASS=1, ERR_CNT=0, FLAG_ERR=0.
- Corrupt entry 4 (bit 4 stuck 0, read 0x000 instead of 0x010) → ERR_CNT=1, FAIL_IDX=4, PASS=0; DONE timing unchanged.
- FULL forced high after 7 writes → W_EN stops after 7; FLAG_ERR=1; PASS=0; sequence still reaches DONE.
- FULL never asserts; EMPTY stuck low after drain → FLAG_ERR=1; ERR_CNT=0; PASS=0.
- RST low mid-READ (read index 5), then released → all outputs 0, IDLE. A fresh START completes with PASS=1.
- RD_LAT=3 build, all 10 entries corrupted → ERR_CNT=10, FAIL_IDX=0, DRAIN lasts 3 cycles; START during READ ignored; START in DONE restarts with cleared results.

Source files
------------

// File: rtl/fifo_bist_pkg.sv
// Shared types and helpers for the FIFO BIST sequencer: state encoding,
// default geometry and the walking-ones ring advance.
package fifo_bist_pkg;

  localparam int DEPTH_DEF = 10;
  localparam int WIDTH_DEF = 10;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE      = 3'd0;
  localparam state_t S_WRITE     = 3'd1;
  localparam state_t S_CHK_FULL  = 3'd2;
  localparam state_t S_READ      = 3'd3;
  localparam state_t S_DRAIN     = 3'd4;
  localparam state_t S_CHK_EMPTY = 3'd5;
  localparam state_t S_DONE      = 3'd6;

  // Rotate the low w bits of v left by one; upper bits are forced to zero.
  function automatic logic [31:0] rotl1(input logic [31:0] v, input int w);
    logic [31:0] mask;
    mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

endpackage

// File: rtl/fifo_bist_ctrl_if.sv
// Host + FIFO-side signal bundle of the BIST sequencer.
interface fifo_bist_ctrl_if #(
  parameter int WIDTH = 10,
  parameter int CW    = 4
);
  logic             START;
  logic             FULL;
  logic             EMPTY;
  logic [WIDTH-1:0] RDATA;
  logic             W_EN;
  logic             R_EN;
  logic             BUSY;
  logic             DONE;
  logic             PASS;
  logic [CW-1:0]    ERR_CNT;
  logic [CW-1:0]    FAIL_IDX;
  logic             FLAG_ERR;

  modport master (
    input  START, FULL, EMPTY, RDATA,
    output W_EN, R_EN, BUSY, DONE, PASS, ERR_CNT, FAIL_IDX, FLAG_ERR
  );

  modport slave (
    output START, FULL, EMPTY, RDATA,
    input  W_EN, R_EN, BUSY, DONE, PASS, ERR_CNT, FAIL_IDX, FLAG_ERR
  );
endinterface

// File: rtl/bist_cmp_pipe.sv
// Read-latency valid/index pipe, walking-ones comparator and saturating
// mismatch counter with first-failure index capture.
module bist_cmp_pipe
  import fifo_bist_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int CW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             issue,
  input  logic [CW-1:0]    issue_idx,
  input  logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    err_cnt,
  output logic [CW-1:0]    fail_idx
);

  logic [RD_LAT-1:0]         vld_pipe_q, vld_pipe_d;
  logic [RD_LAT-1:0][CW-1:0] tag_pipe_q, tag_pipe_d;
  logic [WIDTH-1:0]          exp_q, exp_d;
  logic [CW-1:0]             err_cnt_q, err_cnt_d;
  logic [CW-1:0]             fail_idx_q, fail_idx_d;
  logic                      cmp_vld;

  always_comb begin
    vld_pipe_d    = '0;
    tag_pipe_d    = '0;
    vld_pipe_d[0] = issue;
    tag_pipe_d[0] = issue_idx;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      tag_pipe_d[i] = tag_pipe_q[i-1];
    end
    cmp_vld    = vld_pipe_q[RD_LAT-1];
    exp_d      = cmp_vld ? WIDTH'(rotl1(32'(exp_q), WIDTH)) : exp_q;
    err_cnt_d  = err_cnt_q;
    fail_idx_d = fail_idx_q;
    // A zero count means no mismatch yet this pass, so this one is the first.
    if (cmp_vld && (rdata != exp_q)) begin
      if (err_cnt_q == '0) fail_idx_d = tag_pipe_q[RD_LAT-1];
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CW'(1);
    end
    if (clr) begin
      vld_pipe_d = '0;
      tag_pipe_d = '0;
      exp_d      = WIDTH'(1);
      err_cnt_d  = '0;
      fail_idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      exp_q      <= WIDTH'(1);
      err_cnt_q  <= '0;
      fail_idx_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
      exp_q      <= exp_d;
      err_cnt_q  <= err_cnt_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign fail_idx = fail_idx_q;

endmodule

// File: rtl/fifo_bist_ctrl.sv
// BIST sequencer for a DEPTH x WIDTH FIFO: fill, full check, drain with
// data compare, empty check; results held in DONE until the next START.
module fifo_bist_ctrl
  import fifo_bist_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int RD_LAT = 1,
  parameter int CW     = 4
) (
  input  logic             CLK,
  input  logic             RST,
  fifo_bist_ctrl_if.master bus
);

  localparam logic [CW-1:0] LAST    = CW'(DEPTH - 1);
  localparam logic [CW-1:0] DR_LAST = CW'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_err_q, flag_err_d;
  logic          pass_q, pass_d;
  logic          w_en, r_en, clr;
  logic [CW-1:0] err_cnt, fail_idx;

  // One counter serves the write, read and drain phases; it is zeroed on
  // every phase change, so in READ it doubles as the read index tag.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flag_err_d = flag_err_q;
    pass_d     = pass_q;
    w_en       = 1'b0;
    r_en       = 1'b0;
    clr        = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.START) begin
          clr        = 1'b1;
          state_d    = S_WRITE;
          cnt_d      = '0;
          flag_err_d = 1'b0;
          pass_d     = 1'b0;
        end
      end
      S_WRITE: begin
        w_en = !bus.FULL;
        if (bus.FULL) begin
          flag_err_d = 1'b1;
          state_d    = S_CHK_FULL;
          cnt_d      = '0;
        end else if (cnt_q == LAST) begin
          state_d = S_CHK_FULL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHK_FULL: begin
        if (!bus.FULL) flag_err_d = 1'b1;
        state_d = S_READ;
      end
      S_READ: begin
        r_en = !bus.EMPTY;
        if (bus.EMPTY) begin
          flag_err_d = 1'b1;
          state_d    = S_DRAIN;
          cnt_d      = '0;
        end else if (cnt_q == LAST) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == DR_LAST) begin
          state_d = S_CHK_EMPTY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CHK_EMPTY: begin
        if (!bus.EMPTY) flag_err_d = 1'b1;
        state_d = S_DONE;
        pass_d  = (err_cnt == '0) && !flag_err_d;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      flag_err_q <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flag_err_q <= flag_err_d;
      pass_q     <= pass_d;
    end
  end

  bist_cmp_pipe #(
    .WIDTH  (WIDTH),
    .CW     (CW),
    .RD_LAT (RD_LAT)
  ) u_cmp (
    .clk       (CLK),
    .rst_n     (RST),
    .clr       (clr),
    .issue     (r_en),
    .issue_idx (cnt_q),
    .rdata     (bus.RDATA),
    .err_cnt   (err_cnt),
    .fail_idx  (fail_idx)
  );

  assign bus.W_EN     = w_en;
  assign bus.R_EN     = r_en;
  assign bus.BUSY     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.DONE     = (state_q == S_DONE);
  assign bus.PASS     = pass_q;
  assign bus.ERR_CNT  = err_cnt;
  assign bus.FAIL_IDX = fail_idx;
  assign bus.FLAG_ERR = flag_err_q;

endmodule

// File: tb/tb_fifo_bist_ctrl.sv
// Bench for fifo_bist_ctrl: RD_LAT=1 and RD_LAT=3 instances, each driving a
// behavioural FIFO with fault knobs; expected results derived per pass.
module tb_fifo_bist_ctrl;

  localparam int DEPTH = 10;
  localparam int WIDTH = 10;
  localparam int CW    = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [1:0]          start_v;
  logic [1:0]          busy_v, done_v, pass_v, flag_v, wen_v, ren_v;
  logic [1:0][CW-1:0]  err_v, idx_v;
  logic [1:0][15:0]    corrupt_m;
  logic [1:0]          empty_bad;
  int                  full_at [2];
  int                  n_chk = 0;
  int                  n_pass = 0;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    fifo_bist_ctrl_if #(.WIDTH(WIDTH), .CW(CW)) bus ();
    fifo_bist_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(LAT), .CW(CW)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
    );

    // Ideal FIFO fed by a walking-ones generator, with injectable faults:
    // corrupted entries read as zero, FULL at a chosen fill level, EMPTY stuck low.
    logic [WIDTH-1:0] mem   [16];
    logic [WIDTH-1:0] rpipe [LAT];
    int wr_n = 0, rd_n = 0, cnt = 0;

    assign bus.START = start_v[g];
    assign bus.FULL  = (cnt >= full_at[g]);
    assign bus.EMPTY = (cnt == 0) && !empty_bad[g];
    assign bus.RDATA = rpipe[LAT-1];

    always @(posedge CLK) begin
      if (bus.START && !bus.BUSY) begin
        wr_n <= 0;
        rd_n <= 0;
        cnt  <= 0;
      end else begin
        if (bus.W_EN) begin
          mem[wr_n % 16] <= WIDTH'(1) << (wr_n % WIDTH);
          wr_n <= wr_n + 1;
        end
        if (bus.R_EN) rd_n <= rd_n + 1;
        cnt <= cnt + (bus.W_EN ? 1 : 0) - ((bus.R_EN && cnt > 0) ? 1 : 0);
      end
      rpipe[0] <= (bus.R_EN && !corrupt_m[g][rd_n % 16]) ? mem[rd_n % 16] : '0;
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    assign busy_v[g] = bus.BUSY;
    assign done_v[g] = bus.DONE;
    assign pass_v[g] = bus.PASS;
    assign flag_v[g] = bus.FLAG_ERR;
    assign wen_v[g]  = bus.W_EN;
    assign ren_v[g]  = bus.R_EN;
    assign err_v[g]  = bus.ERR_CNT;
    assign idx_v[g]  = bus.FAIL_IDX;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic chk_idle(input int g, input string tag);
    chk({tag, "_busy"}, busy_v[g], 0);
    chk({tag, "_done"}, done_v[g], 0);
    chk({tag, "_pass"}, pass_v[g], 0);
    chk({tag, "_err"},  err_v[g],  0);
    chk({tag, "_idx"},  idx_v[g],  0);
    chk({tag, "_flag"}, flag_v[g], 0);
    chk({tag, "_wen"},  wen_v[g],  0);
    chk({tag, "_ren"},  ren_v[g],  0);
  endtask

  // One full pass; expectations come from the pass rules, not the FSM.
  task automatic run_pass(input int g, input logic [15:0] cm, input int fa,
                          input logic eb, input bit mid_start);
    int cyc = 0, wen = 0, ren = 0, both = 0, n, writes, reads, lat;
    int e_err = 0, e_idx = 0, e_busy;
    bit e_flag, pulsed = 0;
    corrupt_m[g] = cm;
    full_at[g]   = fa;
    empty_bad[g] = eb;
    @(negedge CLK); start_v[g] = 1'b1;
    @(negedge CLK); start_v[g] = 1'b0;
    chk("start_busy", busy_v[g], 1);
    chk("start_clr_err", err_v[g], 0);
    chk("start_clr_done", done_v[g], 0);
    chk("start_clr_flag", flag_v[g], 0);
    for (n = 0; n < 200; n++) begin
      if (done_v[g]) break;
      if (mid_start && !pulsed && ren == 3) begin
        start_v[g] = 1'b1;
        pulsed = 1;
      end else begin
        start_v[g] = 1'b0;
      end
      if (busy_v[g]) cyc++;
      if (wen_v[g]) wen++;
      if (ren_v[g]) ren++;
      if (wen_v[g] && ren_v[g]) both++;
      @(negedge CLK);
    end
    start_v[g] = 1'b0;
    chk("done_reached", (n < 200) ? 1 : 0, 1);

    lat    = (g == 0) ? 1 : 3;
    writes = (fa < DEPTH) ? fa : DEPTH;
    reads  = eb ? DEPTH : writes;
    e_flag = (fa != DEPTH) || eb || (reads < DEPTH);
    for (int i = 0; i < reads; i++)
      if (cm[i]) begin
        if (e_err == 0) e_idx = i;
        e_err++;
      end
    e_busy = writes + ((writes < DEPTH) ? 1 : 0) + 1 +
             reads + ((reads < DEPTH) ? 1 : 0) + lat + 1;

    chk("busy_cycles", cyc, e_busy);
    chk("wen_pulses", wen, writes);
    chk("ren_pulses", ren, reads);
    chk("wen_ren_overlap", both, 0);
    chk("busy_in_done", busy_v[g], 0);
    chk("err_cnt", err_v[g], e_err);
    chk("fail_idx", idx_v[g], e_idx);
    chk("flag_err", flag_v[g], e_flag ? 1 : 0);
    chk("pass", pass_v[g], (e_err == 0 && !e_flag) ? 1 : 0);
    repeat (3) @(negedge CLK);
    chk("done_held", done_v[g], 1);
    chk("err_held", err_v[g], e_err);
  endtask

  initial begin
    int r;
    start_v   = '0;
    corrupt_m = '0;
    empty_bad = '0;
    full_at[0] = DEPTH;
    full_at[1] = DEPTH;
    #2 RST = 1'b0;
    repeat (3) @(negedge CLK);
    chk_idle(0, "rst0");
    chk_idle(1, "rst1");
    RST = 1'b1;

    run_pass(0, 16'h0000, DEPTH, 1'b0, 0);   // clean pass, 23 cycles
    run_pass(0, 16'h0010, DEPTH, 1'b0, 0);   // entry 4 reads back 0
    run_pass(0, 16'h0000, 7,     1'b0, 0);   // FULL early after 7 writes
    run_pass(0, 16'h0000, 99,    1'b1, 0);   // FULL never, EMPTY stuck low

    // Abort mid-READ with errors already counted; nothing may survive.
    corrupt_m[0] = 16'h000E;
    full_at[0]   = DEPTH;
    empty_bad[0] = 1'b0;
    @(negedge CLK); start_v[0] = 1'b1;
    @(negedge CLK); start_v[0] = 1'b0;
    r = 0;
    for (int n = 0; n < 100 && r < 5; n++) begin
      if (ren_v[0]) r++;
      if (r < 5) @(negedge CLK);
    end
    chk("mid_read_reached", r, 5);
    RST = 1'b0;
    #1 chk_idle(0, "abort");
    @(negedge CLK); RST = 1'b1;
    repeat (2) @(negedge CLK);
    chk("abort_stays_idle", busy_v[0], 0);
    run_pass(0, 16'h0000, DEPTH, 1'b0, 0);

    run_pass(1, 16'h03FF, DEPTH, 1'b0, 1);   // RD_LAT=3, all corrupt, START mid-READ
    run_pass(1, 16'h0000, DEPTH, 1'b0, 0);   // restart from DONE clears results

    for (int k = 0; k < 12; k++) begin
      int g, sel, fa;
      logic eb;
      g   = $urandom_range(0, 1);
      sel = $urandom_range(0, 3);
      fa  = (sel == 0) ? $urandom_range(1, DEPTH - 1) : (sel == 1) ? 99 : DEPTH;
      eb  = (fa >= DEPTH) && ($urandom_range(0, 3) == 0);
      run_pass(g, 16'($urandom) & 16'h03FF, fa, eb, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
